// File: rtl/gate_truth_decoder_pkg.sv
// Shared gate identifiers and golden 4-bit truth tables, indexed as truth[{a,b}].
// Also holds the decoder FSM state type.
package gate_truth_decoder_pkg;

  localparam logic [2:0] GATE_AND     = 3'd0;
  localparam logic [2:0] GATE_OR      = 3'd1;
  localparam logic [2:0] GATE_NOT_A   = 3'd2;
  localparam logic [2:0] GATE_NAND    = 3'd3;
  localparam logic [2:0] GATE_NOR     = 3'd4;
  localparam logic [2:0] GATE_XOR     = 3'd5;
  localparam logic [2:0] GATE_XNOR    = 3'd6;
  localparam logic [2:0] GATE_UNKNOWN = 3'd7;

  localparam logic [3:0] TRUTH_AND   = 4'b1000;
  localparam logic [3:0] TRUTH_OR    = 4'b1110;
  localparam logic [3:0] TRUTH_NOT_A = 4'b0011;
  localparam logic [3:0] TRUTH_NAND  = 4'b0111;
  localparam logic [3:0] TRUTH_NOR   = 4'b0001;
  localparam logic [3:0] TRUTH_XOR   = 4'b0110;
  localparam logic [3:0] TRUTH_XNOR  = 4'b1001;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDecode
  } state_e;

endpackage

// File: rtl/gate_truth_lut.sv
// Combinational decode of a captured truth table into a gate ID.
// Unrecognised patterns give GATE_UNKNOWN with id_valid low.
module gate_truth_lut
  import gate_truth_decoder_pkg::*;
(
  input  logic [3:0] truth,
  output logic [2:0] gate_id,
  output logic       id_valid
);

  always_comb begin
    gate_id  = GATE_UNKNOWN;
    id_valid = 1'b1;
    case (truth)
      TRUTH_AND:   gate_id = GATE_AND;
      TRUTH_OR:    gate_id = GATE_OR;
      TRUTH_NOT_A: gate_id = GATE_NOT_A;
      TRUTH_NAND:  gate_id = GATE_NAND;
      TRUTH_NOR:   gate_id = GATE_NOR;
      TRUTH_XOR:   gate_id = GATE_XOR;
      TRUTH_XNOR:  gate_id = GATE_XNOR;
      default:     id_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_truth_decoder.sv
// Sweeps the four input combinations of a two-input gate, captures its truth table
// and decodes it into a gate ID.
module gate_truth_decoder
  import gate_truth_decoder_pkg::*;
#(
  parameter int unsigned SETTLE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       y_in,
  output logic       a_drv,
  output logic       b_drv,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth,
  output logic [2:0] gate_id,
  output logic       id_valid
);

  localparam logic [3:0] HoldLast = 4'(SETTLE);

  state_e     state_q, state_d;
  logic [1:0] k_q, k_d;
  logic [3:0] hold_q, hold_d;
  logic [3:0] truth_q, truth_d;
  logic [2:0] gate_id_q, gate_id_d;
  logic       id_valid_q, id_valid_d;
  logic [2:0] lut_id;
  logic       lut_valid;
  logic       sample;

  assign sample = (state_q == StDrive) && (hold_q == HoldLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StDrive;
      StDrive:  if (sample && (k_q == 2'd3)) state_d = StDecode;
      StDecode: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    busy  = (state_q == StDrive);
    done  = (state_q == StDecode);
    a_drv = k_q[1];
    b_drv = k_q[0];
  end

  always_comb begin
    k_d     = k_q;
    hold_d  = hold_q;
    truth_d = truth_q;
    if ((state_q == StIdle) && start) begin
      k_d    = 2'd0;
      hold_d = 4'd0;
    end else if (state_q == StDrive) begin
      if (sample) begin
        truth_d[k_q] = y_in;
        hold_d       = 4'd0;
        // k parks at 3 so the drivers keep the last combination while idle
        if (k_q != 2'd3) k_d = k_q + 2'd1;
      end else begin
        hold_d = hold_q + 4'd1;
      end
    end
  end

  // Decode the table including the final sample so the ID is visible in DECODE itself
  gate_truth_lut u_lut (
    .truth    (truth_d),
    .gate_id  (lut_id),
    .id_valid (lut_valid)
  );

  always_comb begin
    gate_id_d  = gate_id_q;
    id_valid_d = id_valid_q;
    if ((state_q == StDrive) && (state_d == StDecode)) begin
      gate_id_d  = lut_id;
      id_valid_d = lut_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q        <= 2'd0;
      hold_q     <= 4'd0;
      truth_q    <= 4'd0;
      gate_id_q  <= GATE_UNKNOWN;
      id_valid_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      hold_q     <= hold_d;
      truth_q    <= truth_d;
      gate_id_q  <= gate_id_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign truth    = truth_q;
  assign gate_id  = gate_id_q;
  assign id_valid = id_valid_q;

endmodule

// File: tb/tb_gate_truth_decoder.sv
// Bench for gate_truth_decoder: one instance with SETTLE=1 and one with SETTLE=0,
// each looped back through a behavioural gate selected by a mode number.
module tb_gate_truth_decoder;

  typedef struct {
    int         d;
    int         f;
    logic [3:0] truth;
    logic [2:0] id;
    logic       valid;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_v [2];
  int         mode_v [2];
  logic [3:0] rtab = 4'd0;

  logic       a0, b0, busy0, done0, val0, y0;
  logic       a1, b1, busy1, done1, val1, y1;
  logic [3:0] truth0, truth1;
  logic [2:0] gid0, gid1;

  logic [1:0] ab_v [2];
  logic       busy_v [2];
  logic       done_v [2];
  logic       val_v [2];
  logic [3:0] truth_v [2];
  logic [2:0] gid_v [2];

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Modes 0..6 are the named gates, 7/8 constant 1/0, 10 a random table in rtab
  function automatic logic gate_fn(input int f, input logic a, input logic b);
    case (f)
      0: return a & b;
      1: return a | b;
      2: return ~a;
      3: return ~(a & b);
      4: return ~(a | b);
      5: return a ^ b;
      6: return ~(a ^ b);
      7: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  always_comb begin
    y0 = (mode_v[0] == 10) ? rtab[{a0, b0}] : gate_fn(mode_v[0], a0, b0);
    y1 = (mode_v[1] == 10) ? rtab[{a1, b1}] : gate_fn(mode_v[1], a1, b1);
  end

  always_comb begin
    ab_v[0] = {a0, b0};     ab_v[1] = {a1, b1};
    busy_v[0] = busy0;      busy_v[1] = busy1;
    done_v[0] = done0;      done_v[1] = done1;
    val_v[0] = val0;        val_v[1] = val1;
    truth_v[0] = truth0;    truth_v[1] = truth1;
    gid_v[0] = gid0;        gid_v[1] = gid1;
  end

  gate_truth_decoder #(.SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .y_in(y0), .a_drv(a0), .b_drv(b0),
    .busy(busy0), .done(done0), .truth(truth0), .gate_id(gid0), .id_valid(val0)
  );

  gate_truth_decoder #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .y_in(y1), .a_drv(a1), .b_drv(b1),
    .busy(busy1), .done(done1), .truth(truth1), .gate_id(gid1), .id_valid(val1)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: evaluate the function on every input pair, then identify it by
  // comparing against the tables of the seven named gate functions.
  function automatic logic [3:0] model_truth(input int f);
    logic [3:0] t;
    for (int i = 0; i < 4; i++) begin
      t[i] = (f == 10) ? rtab[i] : gate_fn(f, i[1], i[0]);
    end
    return t;
  endfunction

  function automatic logic [3:0] model_id(input logic [3:0] t);
    for (int g = 0; g < 7; g++) begin
      if (model_truth(g) == t) return {1'b1, 3'(g)};
    end
    return {1'b0, 3'd7};
  endfunction

  task automatic check_reset_vals(input int d, input string nm);
    chk({nm, " ab"}, 32'(ab_v[d]), 32'd0);
    chk({nm, " busy/done"}, {30'd0, busy_v[d], done_v[d]}, 32'd0);
    chk({nm, " truth"}, 32'(truth_v[d]), 32'd0);
    chk({nm, " id/valid"}, {28'd0, val_v[d], gid_v[d]}, 32'h7);
  endtask

  task automatic sweep(input int d, input int f, input logic [3:0] et, input logic [2:0] eid,
                       input logic ev, input string nm);
    int hold = (d == 1) ? 2 : 1;
    int lat = 4 * hold + 1;
    int drv_err = 0;
    int done_cnt = 0;
    int done_at = -1;
    mode_v[d] = f;
    @(negedge clk);
    start_v[d] = 1'b1;
    for (int c = 1; c <= lat + 2; c++) begin
      @(negedge clk);
      start_v[d] = 1'b0;
      if (c <= 4 * hold) begin
        if (ab_v[d] != 2'((c - 1) / hold) || !busy_v[d] || done_v[d]) drv_err++;
      end
      if (done_v[d]) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == lat) begin
        chk({nm, " truth"}, 32'(truth_v[d]), 32'(et));
        chk({nm, " gate_id"}, 32'(gid_v[d]), 32'(eid));
        chk({nm, " id_valid/busy"}, {30'd0, val_v[d], busy_v[d]}, {30'd0, ev, 1'b0});
      end
    end
    chk({nm, " drive sequence"}, 32'(drv_err), 32'd0);
    chk({nm, " done cycle/count"}, {16'(done_at), 16'(done_cnt)}, {16'(lat), 16'd1});
  endtask

  vec_t vecs [10];

  initial begin
    int err;
    int dcnt;
    logic [3:0] et;
    logic [3:0] em;

    vecs[0] = '{1, 0, 4'b1000, 3'd0, 1'b1, "AND s1"};
    vecs[1] = '{1, 1, 4'b1110, 3'd1, 1'b1, "OR s1"};
    vecs[2] = '{1, 2, 4'b0011, 3'd2, 1'b1, "NOT_A s1"};
    vecs[3] = '{1, 3, 4'b0111, 3'd3, 1'b1, "NAND s1"};
    vecs[4] = '{1, 4, 4'b0001, 3'd4, 1'b1, "NOR s1"};
    vecs[5] = '{1, 5, 4'b0110, 3'd5, 1'b1, "XOR s1"};
    vecs[6] = '{1, 6, 4'b1001, 3'd6, 1'b1, "XNOR s1"};
    vecs[7] = '{0, 7, 4'b1111, 3'd7, 1'b0, "CONST1 s0"};
    vecs[8] = '{0, 5, 4'b0110, 3'd5, 1'b1, "XOR s0"};
    vecs[9] = '{1, 8, 4'b0000, 3'd7, 1'b0, "CONST0 s1"};

    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    mode_v[0] = 0;
    mode_v[1] = 0;
    repeat (3) @(negedge clk);
    check_reset_vals(0, "reset dut0");
    check_reset_vals(1, "reset dut1");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      sweep(vecs[i].d, vecs[i].f, vecs[i].truth, vecs[i].id, vecs[i].valid, vecs[i].name);
    end

    // Randomised tables on both instances against the reference model
    for (int i = 0; i < 12; i++) begin
      rtab = 4'($urandom_range(0, 15));
      et = model_truth(10);
      em = model_id(et);
      sweep(i % 2, 10, et, em[2:0], em[3], $sformatf("random %0d tab=%b", i, rtab));
    end

    // Extra start pulses during DRIVE and DECODE must not restart the sweep
    mode_v[1] = 1;
    err = 0;
    dcnt = 0;
    @(negedge clk);
    start_v[1] = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      if (done1) begin
        dcnt++;
        if (c != 9) err++;
      end
      if (c >= 10 && busy1) err++;
      start_v[1] = (c == 3 || c == 9);
    end
    chk("start while busy: stray done/busy", 32'(err), 32'd0);
    chk("start while busy: done count", 32'(dcnt), 32'd1);

    // Reset asserted during cycle 4 of an XOR sweep
    mode_v[1] = 5;
    err = 0;
    @(negedge clk);
    start_v[1] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start_v[1] = 1'b0;
      if (c == 4) rst_n = 1'b0;
    end
    check_reset_vals(1, "mid-sweep reset");
    rst_n = 1'b1;
    for (int c = 6; c <= 20; c++) begin
      @(negedge clk);
      if (done1 || busy1) err++;
    end
    chk("mid-sweep reset: no done afterwards", 32'(err), 32'd0);
    sweep(1, 5, 4'b0110, 3'd5, 1'b1, "XOR after reset");

    // Retention after an AND result
    sweep(1, 0, 4'b1000, 3'd0, 1'b1, "AND before idle");
    mode_v[1] = 1;
    err = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done1 || gid1 != 3'd0 || !val1 || truth1 != 4'b1000 || {a1, b1} != 2'b11) err++;
    end
    chk("retention over 20 idle cycles", 32'(err), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
